// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding.
// Used by serial_add_ctrl (optional subtract mode: SERIAL_ADD_SUB_EN).
package serial_add_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder, the only arithmetic in the serial adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder_bit reused over WIDTH cycles, LSB first.
// Build option SERIAL_ADD_SUB_EN adds a 'sub' port selecting a - b (two's complement).
//
// state | meaning
// IDLE  | waiting for an operand pair, start_ready high
// RUN   | one operand bit per cycle through the shared adder
// DONE  | result presented, waiting for done_ready
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_BIT  = WIDTH'(1) << (WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic [WIDTH-1:0] s_sh_d;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             done_valid_q;
    logic             start_ready_q;
    logic             busy_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder_bit u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_sum),
        .co (fa_cout)
    );

`ifdef SERIAL_ADD_SUB_EN
    // Subtract as a + ~b + 1; cout=1 then means no borrow.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // Written as shift-or so WIDTH=1 needs no zero-width slice.
    assign s_sh_d = (s_sh_q >> 1) | (fa_sum ? MSB_BIT : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            s_sh_q        <= '0;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_sh_q        <= a;
                        b_sh_q        <= b_load;
                        carry_q       <= carry_load;
                        s_sh_q        <= '0;
                        cnt_q         <= '0;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= s_sh_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        sum_q        <= s_sh_d;
                        cout_q       <= fa_cout;
                        done_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid_q  <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    done_valid_q  <= 1'b0;
                    start_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign done_valid  = done_valid_q;
    assign busy        = busy_q;

endmodule
